// File: rtl/bootrom_fetch_if.sv
// ROM port (CEN/A/Q) and output stream (valid/ready) of the boot ROM read initiator.
// Stream handshake: a beat transfers on a rising clock edge when M_VALID && M_READY; M_VALID/M_DATA/M_LAST hold while M_READY=0.
interface bootrom_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  CEN;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] Q;
    logic                  M_VALID;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_LAST;
    logic                  M_READY;

    modport master (
        output CEN, A, M_VALID, M_DATA, M_LAST,
        input  Q, M_READY
    );

    modport slave (
        input  CEN, A, M_VALID, M_DATA, M_LAST,
        output Q, M_READY
    );
endinterface

// File: rtl/bootrom_fetch.sv
// Boot ROM read initiator: on START reads LEN consecutive words through a single-cycle ROM
// and streams them out through a small credit-controlled FIFO.
module bootrom_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [15:0]           LEN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [1:0]            dbg_state,
    bootrom_fetch_if.master       bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [15:0]             remaining;
    logic                    inflight;
    logic                    inflight_last;
    logic [DATA_WIDTH-1:0]   buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]    buf_last;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           occ;
    logic                    done_q;

    logic                    valid;
    logic                    pop;
    logic [CW-1:0]           credit;
    logic                    issue;

    // A pop this cycle frees a slot for a read issued this cycle, since the
    // read data only lands in the buffer at the end of the next cycle.
    always_comb begin
        valid  = (occ != '0);
        pop    = valid && bus.M_READY;
        credit = DEPTH_C - occ - CW'(inflight) + CW'(pop);
        issue  = (state == ST_FETCH) && (remaining != 16'd0) && (credit != '0);
    end

    assign bus.CEN     = ~issue;
    assign bus.A       = addr;
    assign bus.M_VALID = valid;
    assign bus.M_DATA  = buf_data[rd_ptr];
    assign bus.M_LAST  = valid & buf_last[rd_ptr];
    assign BUSY        = (state != ST_IDLE);
    assign DONE        = done_q;
    assign dbg_state   = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= 16'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            done_q        <= 1'b0;
            buf_last      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;

            if (inflight) begin
                buf_data[wr_ptr] <= bus.Q;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ <= occ + CW'(inflight) - CW'(pop);

            inflight      <= issue;
            inflight_last <= issue && (remaining == 16'd1);
            if (issue) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (START) begin
                        addr      <= BASE_ADDR;
                        remaining <= LEN;
                        if (LEN != 16'd0) begin
                            state <= ST_FETCH;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue && (remaining == 16'd1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The tagged last word leaving an otherwise empty pipe ends the request.
                    if (pop && bus.M_LAST && !inflight && (occ == CW'(1))) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bootrom_fetch.sv
// Bench for bootrom_fetch: ROM models, a read/stream scoreboard and directed request scenarios.
module tb_bootrom_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_w;
    logic [31:0] base;
    logic [10:0] base_w;
    logic [15:0] len, len_w;
    logic        busy, done, busy_w, done_w;
    logic [1:0]  st, st_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] addr_q [$];
    logic [32:0] exp_q [$];
    int          cen_cyc_q [$];
    int          pop_cyc_q [$];
    int          last_cyc_q [$];
    int          done_cyc_q [$];
    logic [32:0] exp_e;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_data;

    bootrom_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    bootrom_fetch_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus_w ();

    bootrom_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BUF_DEPTH(2)) dut (
        .CLK(clk), .RST(rst), .START(start), .BASE_ADDR(base), .LEN(len),
        .BUSY(busy), .DONE(done), .dbg_state(st), .bus(bus)
    );

    bootrom_fetch #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .BUF_DEPTH(2)) dut_w (
        .CLK(clk), .RST(rst), .START(start_w), .BASE_ADDR(base_w), .LEN(len_w),
        .BUSY(busy_w), .DONE(done_w), .dbg_state(st_w), .bus(bus_w)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: word[i] = 0xA000_0000 + i, one cycle latency
    always @(posedge clk) if (!bus.CEN) bus.Q <= 32'hA000_0000 + bus.A;
    always @(posedge clk) if (!bus_w.CEN) bus_w.Q <= 32'hA000_0000 + {21'd0, bus_w.A};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cen_at(input int idx);
        return (idx < cen_cyc_q.size()) ? cen_cyc_q[idx] : -1;
    endfunction
    function automatic int pop_at(input int idx);
        return (idx < pop_cyc_q.size()) ? pop_cyc_q[idx] : -1;
    endfunction
    function automatic int last_at(input int idx);
        return (idx < last_cyc_q.size()) ? last_cyc_q[idx] : -1;
    endfunction
    function automatic int done_at(input int idx);
        return (idx < done_cyc_q.size()) ? done_cyc_q[idx] : -1;
    endfunction

    // monitor / scoreboard on the main DUT
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.CEN) begin
                cen_cyc_q.push_back(cyc);
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rom_addr: unexpected read at A=%0h, no read expected (cycle %0d)", bus.A, cyc);
                end else begin
                    check("rom_addr", bus.A, addr_q.pop_front());
                end
            end
            if (bus.M_VALID && bus.M_READY) begin
                pop_cyc_q.push_back(cyc);
                if (bus.M_LAST) last_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL m_data: unexpected beat %0h, no beat expected (cycle %0d)", bus.M_DATA, cyc);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("m_data", bus.M_DATA, exp_e[31:0]);
                    check("m_last", bus.M_LAST, exp_e[32]);
                end
            end
            if (done) begin
                done_cyc_q.push_back(cyc);
                check("busy_at_done", busy, 0);
            end
            if (hold_pending) begin
                check("hold_valid", bus.M_VALID, 1);
                check("hold_data", bus.M_DATA, hold_data);
            end
            hold_pending = bus.M_VALID && !bus.M_READY;
            hold_data    = bus.M_DATA;
        end else begin
            hold_pending = 1'b0;
        end
    end

    // driver tasks
    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l, output int t0);
        logic [31:0] d;
        @(posedge clk); #1;
        start = 1'b1;
        base  = b;
        len   = l;
        t0    = cyc;
        for (int i = 0; i < int'(l); i++) begin
            d = 32'hA000_0000 + b + i;
            addr_q.push_back(b + i);
            exp_q.push_back({i == int'(l) - 1, d});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        bool_wait: begin
            for (int i = 0; i < budget; i++) begin
                @(posedge clk);
                if (done_cyc_q.size() > d0) disable bool_wait;
            end
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no DONE within %0d cycles, DONE required", budget);
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c0, p0, l0, d0;
        logic [10:0] wa [4];
        wa = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

        rst = 1'b1; start = 1'b0; base = '0; len = '0;
        start_w = 1'b0; base_w = '0; len_w = '0;
        bus.M_READY = 1'b1; bus_w.M_READY = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cen", bus.CEN, 1);
        check("rst_a", bus.A, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", bus.M_VALID, 0);
        check("rst_data", bus.M_DATA, 0);
        check("rst_last", bus.M_LAST, 0);
        check("rst_state", st, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // basic read
        c0 = cen_cyc_q.size(); p0 = pop_cyc_q.size(); l0 = last_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(32'h10, 16'd4, t0);
        wait_done(d0, 50);
        check("basic_cen_cnt", cen_cyc_q.size() - c0, 4);
        check("basic_cen_first", cen_at(c0), t0 + 1);
        check("basic_cen_lastc", cen_at(c0 + 3), t0 + 4);
        check("basic_pop_cnt", pop_cyc_q.size() - p0, 4);
        check("basic_pop_first", pop_at(p0), t0 + 3);
        check("basic_last_cyc", last_at(l0), t0 + 6);
        check("basic_done_cyc", done_at(d0), t0 + 7);
        repeat (3) @(posedge clk);
        check("basic_done_once", done_cyc_q.size() - d0, 1);

        // backpressure
        bus.M_READY = 1'b0;
        c0 = cen_cyc_q.size(); p0 = pop_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(32'h20, 16'd8, t0);
        repeat (9) @(posedge clk);
        #1;
        check("bp_stall_reads", cen_cyc_q.size() - c0, 2);
        check("bp_stall_pops", pop_cyc_q.size() - p0, 0);
        bus.M_READY = 1'b1;
        wait_done(d0, 60);
        check("bp_resume_cyc", cen_at(c0 + 2), t0 + 10);
        check("bp_reads", cen_cyc_q.size() - c0, 8);
        check("bp_pops", pop_cyc_q.size() - p0, 8);
        repeat (3) @(posedge clk);
        check("bp_done_once", done_cyc_q.size() - d0, 1);

        // zero length
        c0 = cen_cyc_q.size(); p0 = pop_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(32'h30, 16'd0, t0);
        check("zero_busy", busy, 0);
        check("zero_valid", bus.M_VALID, 0);
        wait_done(d0, 10);
        check("zero_done_cyc", done_at(d0), t0 + 1);
        repeat (3) @(posedge clk);
        check("zero_reads", cen_cyc_q.size() - c0, 0);
        check("zero_pops", pop_cyc_q.size() - p0, 0);
        check("zero_done_once", done_cyc_q.size() - d0, 1);

        // START while busy is ignored
        c0 = cen_cyc_q.size(); p0 = pop_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(32'h40, 16'd3, t0);
        @(posedge clk); #1;
        start = 1'b1; base = 32'h80; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 40);
        repeat (6) @(posedge clk);
        check("ign_reads", cen_cyc_q.size() - c0, 3);
        check("ign_pops", pop_cyc_q.size() - p0, 3);
        check("ign_done_once", done_cyc_q.size() - d0, 1);

        // address wrap on the 11-bit instance
        @(posedge clk); #1;
        start_w = 1'b1; base_w = 11'h7FE; len_w = 16'd4;
        @(posedge clk); #1;
        start_w = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                check("wrap_cen", bus_w.CEN, 0);
                check("wrap_addr", bus_w.A, wa[k-1]);
            end
            if (k >= 3 && k <= 6) begin
                check("wrap_valid", bus_w.M_VALID, 1);
                check("wrap_data", bus_w.M_DATA, 32'hA000_0000 + {21'd0, wa[k-3]});
                check("wrap_last", bus_w.M_LAST, k == 6);
            end
            if (k == 7) begin
                check("wrap_done", done_w, 1);
                check("wrap_busy", busy_w, 0);
                check("wrap_cen_idle", bus_w.CEN, 1);
            end
        end

        // reset in the middle of a request
        d0 = done_cyc_q.size();
        bus.M_READY = 1'($urandom_range(0, 1));
        pulse_start(32'h100, 16'd16, t0);
        for (int k = 1; k <= 3; k++) begin
            bus.M_READY = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_cen", bus.CEN, 1);
        check("mid_rst_a", bus.A, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", bus.M_VALID, 0);
        check("mid_rst_data", bus.M_DATA, 0);
        check("mid_rst_last", bus.M_LAST, 0);
        addr_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.M_READY = 1'b1;
        repeat (5) @(posedge clk);
        check("mid_rst_no_done", done_cyc_q.size() - d0, 0);
        c0 = cen_cyc_q.size(); p0 = pop_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(32'h200, 16'd2, t0);
        wait_done(d0, 30);
        check("post_rst_reads", cen_cyc_q.size() - c0, 2);
        check("post_rst_pops", pop_cyc_q.size() - p0, 2);
        check("post_rst_done_cyc", done_at(d0), t0 + 5);

        repeat (3) @(posedge clk);
        check("addr_q_empty", addr_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
